alu_seq: RTL and testbench

Parametrised, handshaked N-bit ALU that extends the team's combinational 4-bit ALU. It adds registered results, valid/ready flow control on both sides, XOR and shift operations, signed flags, and an optional iterative multiplier. It sits between an operand-issuing controller and a result consumer, and handles one operation at a time.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked N-bit ALU with registered results, signed flags and shifts.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // in_ready looks straight through to out_ready so a consumed result can be
  // replaced by a new op in the same cycle (full throughput).
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  logic [SW-1:0]  amt;
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;

  assign amt     = b[SW-1:0];
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  // The extra bit catches the last bit shifted out; it is 0 when amt is 0.
  assign shl_ext = {1'b0, a} << amt;
  assign shr_ext = {a, 1'b0} >> amt;

  logic [WIDTH-1:0] n_res;
  logic             n_carry;
  logic             n_ovf;
  logic             n_ill;
  logic             n_zero;
  logic             n_neg;

  always_comb begin
    n_res   = '0;
    n_carry = 1'b0;
    n_ovf   = 1'b0;
    n_ill   = 1'b0;
    case (sel)
      OP_ADD: begin
        n_res   = add_ext[WIDTH-1:0];
        n_carry = add_ext[WIDTH];
        n_ovf   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        n_res   = sub_ext[WIDTH-1:0];
        n_carry = sub_ext[WIDTH];
        n_ovf   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_AND: n_res = a & b;
      OP_OR:  n_res = a | b;
      OP_XOR: n_res = a ^ b;
      OP_SHL: begin
        n_res   = shl_ext[WIDTH-1:0];
        n_carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        n_res   = shr_ext[WIDTH:1];
        n_carry = shr_ext[0];
      end
      OP_MUL: begin
`ifndef ALU_MUL_EN
        n_ill = 1'b1;
`endif
      end
    endcase
    n_zero = (n_res == '0);
    n_neg  = n_res[MSB];
  end

`ifdef ALU_MUL_EN
  localparam int CW = SW + 1;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     psum;

  // prod starts as {0, b}; each step adds a to the upper half when the
  // current multiplier bit is set, then shifts right by one.
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (sel == OP_MUL) begin
              state     <= S_MUL;
              out_valid <= 1'b0;
              mcand     <= a;
              prod      <= {{WIDTH{1'b0}}, b};
              cnt       <= '0;
            end else
`endif
            begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= n_res;
              result_hi <= '0;
              carry     <= n_carry;
              zero      <= n_zero;
              negative  <= n_neg;
              overflow  <= n_ovf;
              illegal   <= n_ill;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          // WIDTH accumulate cycles, then one cycle to publish the product.
          if (cnt == CW'(WIDTH)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
            carry     <= 1'b0;
            zero      <= (prod == '0);
            negative  <= prod[MSB];
            overflow  <= 1'b0;
            illegal   <= 1'b0;
          end else begin
            prod <= {psum, prod[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8); follows ALU_MUL_EN like the RTL.
module tb_alu_seq;

  localparam int W  = 8;
  localparam int PW = 2 * W + 5;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
  localparam bit MUL_ON  = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_ON  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         illegal;

  logic [PW-1:0] obs;
  logic [PW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  assign obs = {result_hi, result, carry, zero, negative, overflow, illegal};

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .negative(negative), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint sx(input longint v);
    longint half;
    half = longint'(1) << (W - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic logic [PW-1:0] model(input longint av, input longint bv, input int s);
    longint mask, half, lo, hi, ss;
    bit c, v, il, z;
    int amt;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    lo = 0; hi = 0; ss = 0; c = 0; v = 0; il = 0;
    amt = int'(bv % W);
    case (s)
      0: begin
        lo = (av + bv) & mask;
        c  = (av + bv) > mask;
        ss = sx(av) + sx(bv);
        v  = (ss > half - 1) || (ss < -half);
      end
      1: begin
        lo = (av - bv) & mask;
        c  = av >= bv;
        ss = sx(av) - sx(bv);
        v  = (ss > half - 1) || (ss < -half);
      end
      2: lo = av & bv;
      3: lo = av | bv;
      4: lo = av ^ bv;
      5: begin
        lo = (av << amt) & mask;
        c  = (amt != 0) && (((av >> (W - amt)) & 1) == 1);
      end
      6: begin
        lo = av >> amt;
        c  = (amt != 0) && (((av >> (amt - 1)) & 1) == 1);
      end
      default: begin
        if (MUL_ON) begin
          lo = (av * bv) & mask;
          hi = (av * bv) >> W;
        end else begin
          il = 1;
        end
      end
    endcase
    z = (lo == 0) && (hi == 0);
    return {hi[W-1:0], lo[W-1:0], c, z, lo[W-1], v, il};
  endfunction

  // Driver: called at a negedge; returns cycles from acceptance to out_valid
  // and how many of the intermediate cycles showed in_ready high.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] s,
                       output int lat, output int ready_hits);
    int wait_n;
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait: in_ready=%b required 1", in_ready);
    end
    a = av; b = bv; sel = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ready_hits = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_hits++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", obs, {PW{1'b0}});
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0]  ta [12];
    logic [W-1:0]  tb_ [12];
    logic [2:0]    ts [12];
    logic [PW-1:0] tx [12];
    int lat, hits;
    ta  = '{8'd200, 8'd5, 8'd3, 8'h7F, 8'h81, 8'hF0, 8'hFF, 8'h81, 8'h81, 8'hF0, 8'h80, 8'h80};
    tb_ = '{8'd100, 8'd5, 8'd5, 8'h01, 8'h01, 8'hFF, 8'h0B, 8'h01, 8'h00, 8'h0F, 8'h01, 8'h01};
    ts  = '{3'd0,   3'd1, 3'd1, 3'd0,  3'd5,  3'd4,  3'd5,  3'd6,  3'd6,  3'd2,  3'd3,  3'd1};
    tx  = '{{8'h00, 8'h2C, 5'b10000},
            {8'h00, 8'h00, 5'b11000},
            {8'h00, 8'hFE, 5'b00100},
            {8'h00, 8'h80, 5'b00110},
            {8'h00, 8'h02, 5'b10000},
            {8'h00, 8'h0F, 5'b00000},
            {8'h00, 8'hF8, 5'b10100},
            {8'h00, 8'h40, 5'b10000},
            {8'h00, 8'h81, 5'b00100},
            {8'h00, 8'h00, 5'b01000},
            {8'h00, 8'h81, 5'b00100},
            {8'h00, 8'h7F, 5'b10010}};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do_op(ta[i], tb_[i], ts[i], lat, hits);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required 1", i, lat);
      end
      checks++;
      if (obs !== tx[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h required %h", i, obs, tx[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || obs !== tx[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: out_valid=%b obs=%h required 0/%h", i, out_valid, obs, tx[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [PW-1:0] want;
    logic [W-1:0]  ra, rb;
    int lat, hits;
`ifdef ALU_MUL_EN
    want = {8'hFE, 8'h01, 5'b00000};
`else
    want = {8'h00, 8'h00, 5'b01001};
`endif
    out_ready = 1'b1;
    do_op(8'hFF, 8'hFF, 3'd7, lat, hits);
    checks++;
    if (lat !== MUL_LAT) begin
      errors++;
      $display("FAIL mul_latency: got %0d required %0d", lat, MUL_LAT);
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL mul_in_ready: in_ready high for %0d cycles required 0", hits);
    end
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL mul_ff_ff: got %h required %h", obs, want);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ra = (i == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      want = model(longint'(ra), longint'(rb), 7);
      do_op(ra, rb, 3'd7, lat, hits);
      checks++;
      if (lat !== MUL_LAT || obs !== want) begin
        errors++;
        $display("FAIL mul_rand[%0d]: a=%h b=%h lat=%0d obs=%h required lat=%0d obs=%h",
                 i, ra, rb, lat, obs, MUL_LAT, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 40;
    logic [PW-1:0] want;
    logic [W-1:0]  ra, rb;
    logic [2:0]    rs;
    out_ready = 1'b1;
    exp_q.delete();
    ra = W'($urandom_range(0, (1 << W) - 1));
    rb = W'($urandom_range(0, (1 << W) - 1));
    rs = 3'($urandom_range(0, MUL_ON ? 6 : 7));
    a = ra; b = rb; sel = rs; in_valid = 1'b1;
    exp_q.push_back(model(longint'(ra), longint'(rb), int'(rs)));
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== want) begin
        errors++;
        $display("FAIL b2b[%0d]: out_valid=%b obs=%h required 1/%h", i, out_valid, obs, want);
      end
      if (i < N) begin
        ra = W'($urandom_range(0, (1 << W) - 1));
        rb = W'($urandom_range(0, (1 << W) - 1));
        rs = 3'($urandom_range(0, MUL_ON ? 6 : 7));
        a = ra; b = rb; sel = rs;
        exp_q.push_back(model(longint'(ra), longint'(rb), int'(rs)));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] held;
    logic [PW-1:0] want_xor;
    int lat, hits;
    held     = {8'h00, 8'h46, 5'b00000};
    want_xor = {8'h00, 8'h0F, 5'b00000};
    out_ready = 1'b0;
    do_op(8'h12, 8'h34, 3'd0, lat, hits);
    checks++;
    if (lat !== 1 || obs !== held) begin
      errors++;
      $display("FAIL bp_first: lat=%0d obs=%h required 1/%h", lat, obs, held);
    end
    a = 8'hF0; b = 8'hFF; sel = 3'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b obs=%h required 1/0/%h",
                 i, out_valid, in_ready, obs, held);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs !== want_xor) begin
      errors++;
      $display("FAIL bp_xor: out_valid=%b obs=%h required 1/%h", out_valid, obs, want_xor);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int lat, hits;
    out_ready = MUL_ON;
    a = 8'hFF; b = 8'hFF; sel = 3'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (MUL_ON) begin
      repeat (3) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_op: obs=%h out_valid=%b in_ready=%b required 0/0/1",
               obs, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    do_op(8'd1, 8'd1, 3'd0, lat, hits);
    checks++;
    if (lat !== 1 || obs !== {8'h00, 8'h02, 5'b00000}) begin
      errors++;
      $display("FAIL reset_then_add: lat=%0d obs=%h required 1/%h", lat, obs, {8'h00, 8'h02, 5'b00000});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
